apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 122 ++++++++++++
 tb/tb_apb_mem_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB3 slave backed by a word-addressed memory with WAIT_STATES access-phase wait cycles.
// Define APB_MEM_PSLVERR_EN to flag out-of-range or misaligned accesses through PSLVERR.
module apb_mem_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_ready;
  logic                  r_slverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_err;
  logic             w_setup;
  logic             w_complete;
  logic             w_mem_we;

  assign w_idx = PADDR[IDX_W+1:2];

`ifdef APB_MEM_PSLVERR_EN
  // MEM_DEPTH is a power of two, so any set bit above the index range means out of range.
  assign w_err = (|PADDR[ADDR_WIDTH-1:IDX_W+2]) | (|PADDR[1:0]);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{PADDR[ADDR_WIDTH-1:IDX_W+2], PADDR[1:0]};
  assign w_err         = 1'b0;
`endif

  assign w_setup    = (r_state == ST_IDLE) && PSEL && !PENABLE;
  assign w_complete = (r_state == ST_ACCESS) && PSEL && PENABLE && r_ready;
  assign w_mem_we   = w_complete && r_write && !r_err && !PRESET;
  // Zero-wait reads must look up the live address during the setup cycle.
  assign w_rd_idx   = (r_state == ST_IDLE) ? w_idx : r_idx;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_prdata <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_err   <= w_err;
            r_cnt   <= LP_WAIT;
            r_state <= ST_ACCESS;
            if (LP_WAIT == 4'd0) begin
              r_ready  <= 1'b1;
              r_slverr <= w_err;
              r_prdata <= (!PWRITE && !w_err) ? r_mem[w_rd_idx] : '0;
            end
          end
        end
        ST_ACCESS: begin
          if (!PSEL || w_complete) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_prdata <= '0;
          end else if (!r_ready) begin
            if (r_cnt == 4'd1) begin
              r_cnt    <= 4'd0;
              r_ready  <= 1'b1;
              r_slverr <= r_err;
              r_prdata <= (!r_write && !r_err) ? r_mem[w_rd_idx] : '0;
            end else if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign PREADY  = r_ready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_slverr;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: two instances (0 and 2 wait states) on separate APB buses.
// Expectations follow APB_MEM_PSLVERR_EN when the bench is built with that macro.
module tb_apb_mem_slave;

  logic        clk = 1'b0;
  logic        preset;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic [31:0] prdata  [2];
  logic        pslverr [2];

  always #5 clk = ~clk;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut_ws0 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut_ws2 (
    .PCLK(clk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1])
  );

  typedef struct {
    int          dut;
    bit          chk_data;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt [2] = '{0, 0};
  logic prev_psel [2] = '{1'b1, 1'b1};

  task automatic chk(input string name, input int dut, input logic [31:0] act,
                     input logic [31:0] exp, input bit quiet);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, dut, act, exp);
    end else if (!quiet) begin
      $display("ok   %s dut%0d: 0x%08h", name, dut, act);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents PREADY in an access cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preset || !psel[k]) acc_cnt[k] = 0;
      else if (penable[k]) acc_cnt[k] = acc_cnt[k] + 1;
      if (!preset && psel[k] && penable[k] && pready[k]) begin
        if (sb.size() == 0 || sb[0].dut != k) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pready dut%0d: got PREADY=1 addr 0x%08h, expected no transfer",
                   k, paddr[k]);
        end else begin
          mon_e = sb.pop_front();
          $display("txn dut%0d %s addr 0x%08h prdata 0x%08h pslverr %0b access_cycles %0d",
                   k, pwrite[k] ? "WR" : "RD", paddr[k], prdata[k], pslverr[k], acc_cnt[k]);
          chk("access_cycles", k, 32'(acc_cnt[k]), 32'(mon_e.acc), 1'b1);
          chk("pslverr", k, {31'd0, pslverr[k]}, {31'd0, mon_e.err}, 1'b1);
          if (mon_e.chk_data) chk("prdata", k, prdata[k], mon_e.rdata, 1'b1);
          acc_cnt[k] = 0;
        end
      end
      if (!psel[k] && !prev_psel[k]) begin
        chk("idle_pready", k, {31'd0, pready[k]}, 32'd0, 1'b1);
        chk("idle_pslverr", k, {31'd0, pslverr[k]}, 32'd0, 1'b1);
        chk("idle_prdata", k, prdata[k], 32'd0, 1'b1);
      end
      prev_psel[k] = psel[k];
    end
  end

  // Called at posedge+1; returns at posedge+1 after the completion edge with PSEL still high.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit chk_data, input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_acc);
    exp_t e;
    bit   got;
    e.dut = k; e.chk_data = chk_data; e.rdata = exp_rd; e.err = exp_err; e.acc = exp_acc;
    sb.push_back(e);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wdata;
    @(posedge clk) #1;
    penable[k] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (pready[k]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL pready_timeout dut%0d: got no PREADY for addr 0x%08h, expected within %0d cycles",
               k, addr, exp_acc);
      void'(sb.pop_back());
    end
    @(posedge clk) #1;
  endtask

  task automatic idle(input int k, input int n);
    psel[k] = 1'b0; penable[k] = 1'b0;
    repeat (n) @(posedge clk) #1;
  endtask

  logic [31:0] exp_w0_rd;
  logic [31:0] exp_404_rd;
  bit          exp_oob_err;

  initial begin
    preset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_pready", k, {31'd0, pready[k]}, 32'd0, 1'b0);
      chk("reset_pslverr", k, {31'd0, pslverr[k]}, 32'd0, 1'b0);
      chk("reset_prdata", k, prdata[k], 32'd0, 1'b0);
    end
    preset = 1'b0;
    @(posedge clk) #1;

    // Zero-wait write then read of the same word.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1);
    idle(0, 1);
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1);
    idle(0, 2);

    // Back-to-back: each setup follows the previous completion directly.
    xfer(0, 1'b1, 32'h0, 32'h1, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b1, 32'h4, 32'h2, 1'b0, 32'h0, 1'b0, 1);
    xfer(0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1, 1'b0, 1);
    xfer(0, 1'b0, 32'h4, 32'h0, 1'b1, 32'h2, 1'b0, 1);
    idle(0, 2);

    // Out-of-range and misaligned writes.
`ifdef APB_MEM_PSLVERR_EN
    exp_oob_err = 1'b1; exp_w0_rd = 32'h1;    exp_404_rd = 32'h0;
`else
    exp_oob_err = 1'b0; exp_w0_rd = 32'hFFFF; exp_404_rd = 32'h2;
`endif
    xfer(0, 1'b1, 32'h400, 32'hFFFF, 1'b0, 32'h0, exp_oob_err, 1);
    idle(0, 1);
    xfer(0, 1'b1, 32'h02, 32'hFFFF, 1'b0, 32'h0, exp_oob_err, 1);
    idle(0, 1);
    xfer(0, 1'b0, 32'h0, 32'h0, 1'b1, exp_w0_rd, 1'b0, 1);
    idle(0, 1);
    xfer(0, 1'b0, 32'h404, 32'h0, 1'b1, exp_404_rd, exp_oob_err, 1);
    idle(0, 1);

    // PSEL and PENABLE both high while idle is not a transfer.
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h10; pwdata[0] = 32'h12345678;
    repeat (2) @(posedge clk) #1;
    idle(0, 2);
    xfer(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1);
    idle(0, 2);

    // Two wait states: PREADY in the third access cycle.
    xfer(1, 1'b1, 32'h04, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 3);
    xfer(1, 1'b0, 32'h04, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 3);
    idle(1, 1);
    xfer(1, 1'b1, 32'h08, 32'h11, 1'b0, 32'h0, 1'b0, 3);
    idle(1, 1);

    // Reset on the edge that would otherwise raise PREADY.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h08; pwdata[1] = 32'h55;
    @(posedge clk) #1;
    penable[1] = 1'b1;
    @(posedge clk) #1;
    preset = 1'b1;
    @(posedge clk) #1;
    chk("reset_abort_pready", 1, {31'd0, pready[1]}, 32'd0, 1'b0);
    preset = 1'b0;
    idle(1, 2);
    xfer(1, 1'b0, 32'h08, 32'h0, 1'b1, 32'h11, 1'b0, 3);
    idle(1, 1);

    // PSEL dropped in the middle of the wait.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h08; pwdata[1] = 32'h77;
    @(posedge clk) #1;
    penable[1] = 1'b1;
    @(posedge clk) #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk) #1;
    chk("abort_pready", 1, {31'd0, pready[1]}, 32'd0, 1'b0);
    idle(1, 3);
    chk("abort_pready_late", 1, {31'd0, pready[1]}, 32'd0, 1'b0);
    xfer(1, 1'b0, 32'h08, 32'h0, 1'b1, 32'h11, 1'b0, 3);
    idle(1, 2);

    for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
